// File: rtl/gate_truth_table_probe.sv
// Sequential characteriser for a 2-input combinational gate: walks {a,b} through
// 00..11, samples the gate output after SETTLE cycles per vector, and decodes the truth table.
module gate_truth_table_probe #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       probe_a,
    output logic       probe_b,
    input  logic       probe_y,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth_table,
    output logic [3:0] gate_id
);
    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    localparam logic [7:0] LAST = 8'(SETTLE - 1);

    state_t     state;
    logic [1:0] index;
    logic [7:0] count;
    logic [2:0] shadow;

    function automatic logic [3:0] decode(input logic [3:0] tt);
        case (tt)
            4'b1000: decode = 4'd1;
            4'b1110: decode = 4'd2;
            4'b0110: decode = 4'd3;
            4'b0111: decode = 4'd4;
            4'b0001: decode = 4'd5;
            4'b1001: decode = 4'd6;
            4'b0011: decode = 4'd7;
            4'b1100: decode = 4'd8;
            4'b0000: decode = 4'd9;
            4'b1111: decode = 4'd10;
            default: decode = 4'd0;
        endcase
    endfunction

    // The final vector's sample goes straight into the result registers so the
    // new table is visible in the same cycle done is high.
    logic [3:0] final_tt;
    assign final_tt = {probe_y, shadow};

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            index       <= 2'd0;
            count       <= 8'd0;
            shadow      <= 3'd0;
            probe_a     <= 1'b0;
            probe_b     <= 1'b0;
            done        <= 1'b0;
            truth_table <= 4'd0;
            gate_id     <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= APPLY;
                        index   <= 2'd0;
                        count   <= 8'd0;
                        probe_a <= 1'b0;
                        probe_b <= 1'b0;
                    end
                end
                APPLY: begin
                    if (count == LAST) begin
                        count <= 8'd0;
                        if (index == 2'd3) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            truth_table <= final_tt;
                            gate_id     <= decode(final_tt);
                            probe_a     <= 1'b0;
                            probe_b     <= 1'b0;
                        end else begin
                            shadow[index]      <= probe_y;
                            index              <= index + 2'd1;
                            {probe_a, probe_b} <= index + 2'd1;
                        end
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    index <= 2'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
